// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: FSM state enum and the
// encoding used on the forward-select outputs.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hz_state_e;

  // fwd select: 0 reads the register file, k selects stage k-1
  localparam int unsigned FWD_RF      = 0;
  localparam int unsigned FWD_STG_OFS = 1;

  // Forward-select code for a given stage index
  function automatic int unsigned fwd_code(input int unsigned stg);
    return stg + FWD_STG_OFS;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode/stage/hazard signal bundle between the pipeline datapath (master)
// and the hazard controller (slave). Optional perf counters appear when
// PIPE_HAZARD_PERF_EN is defined.
interface pipe_hazard_ctrl_if #(
  parameter int N_STG = 3,
  parameter int AW    = 5
);
  localparam int FW = $clog2(N_STG + 1);

  logic                 id_valid_i;
  logic [AW-1:0]        id_rs_i;
  logic [AW-1:0]        id_rt_i;
  logic                 id_rs_use_i;
  logic                 id_rt_use_i;
  logic [N_STG*AW-1:0]  stg_dest_i;
  logic [N_STG-1:0]     stg_wr_i;
  logic [N_STG-1:0]     stg_load_i;
  logic                 redirect_i;
  logic                 halt_req_i;
  logic [FW-1:0]        fwd_rs_o;
  logic [FW-1:0]        fwd_rt_o;
  logic                 stall_o;
  logic                 flush_o;
  logic                 halted_o;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0]          perf_stall_o;
  logic [31:0]          perf_flush_o;

  modport master (
    output id_valid_i, id_rs_i, id_rt_i, id_rs_use_i, id_rt_use_i,
           stg_dest_i, stg_wr_i, stg_load_i, redirect_i, halt_req_i,
    input  fwd_rs_o, fwd_rt_o, stall_o, flush_o, halted_o,
           perf_stall_o, perf_flush_o
  );

  modport slave (
    input  id_valid_i, id_rs_i, id_rt_i, id_rs_use_i, id_rt_use_i,
           stg_dest_i, stg_wr_i, stg_load_i, redirect_i, halt_req_i,
    output fwd_rs_o, fwd_rt_o, stall_o, flush_o, halted_o,
           perf_stall_o, perf_flush_o
  );
`else
  modport master (
    output id_valid_i, id_rs_i, id_rt_i, id_rs_use_i, id_rt_use_i,
           stg_dest_i, stg_wr_i, stg_load_i, redirect_i, halt_req_i,
    input  fwd_rs_o, fwd_rt_o, stall_o, flush_o, halted_o
  );

  modport slave (
    input  id_valid_i, id_rs_i, id_rt_i, id_rs_use_i, id_rt_use_i,
           stg_dest_i, stg_wr_i, stg_load_i, redirect_i, halt_req_i,
    output fwd_rs_o, fwd_rt_o, stall_o, flush_o, halted_o
  );
`endif

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_pick.sv
// fwd_pick: finds the youngest in-flight stage that writes the given source
// register and flags whether that producer is a load whose data is not yet
// available for forwarding.
module fwd_pick
  import pipe_pkg::*;
#(
  parameter int N_STG   = 3,
  parameter int AW      = 5,
  parameter int RDY_STG = 1,
  parameter int FW      = $clog2(N_STG + 1)
) (
  input  logic [N_STG*AW-1:0] stg_dest,
  input  logic [N_STG-1:0]    stg_wr,
  input  logic [N_STG-1:0]    stg_load,
  input  logic [AW-1:0]       src,
  input  logic                src_use,
  output logic [FW-1:0]       sel,
  output logic                load_nr
);

  // Scan oldest to youngest so the youngest match overwrites older ones
  always_comb begin
    sel     = FW'(FWD_RF);
    load_nr = 1'b0;
    for (int i = N_STG - 1; i >= 0; i--) begin
      if (src_use && stg_wr[i] && (src != '0) && (stg_dest[i*AW +: AW] == src)) begin
        sel     = FW'(fwd_code(i));
        load_nr = stg_load[i] && (i < RDY_STG);
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: forwarding select, load-use stall, redirect flush and
// halt drain sequencing for an in-order pipeline.
// Optional macro PIPE_HAZARD_PERF_EN adds saturating stall/flush counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int N_STG   = 3,
  parameter int AW      = 5,
  parameter int RDY_STG = 1
) (
  input logic               clk,
  input logic               rst_n,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int FW = $clog2(N_STG + 1);

  hz_state_e     state;
  logic [FW-1:0] drain_cnt;
  logic          halted;

  logic [FW-1:0] rs_sel, rt_sel;
  logic          rs_lnr, rt_lnr;
  logic          hz_stall;
  logic          halt_go;

  fwd_pick #(.N_STG(N_STG), .AW(AW), .RDY_STG(RDY_STG), .FW(FW)) u_pick_rs (
    .stg_dest (bus.stg_dest_i),
    .stg_wr   (bus.stg_wr_i),
    .stg_load (bus.stg_load_i),
    .src      (bus.id_rs_i),
    .src_use  (bus.id_rs_use_i),
    .sel      (rs_sel),
    .load_nr  (rs_lnr)
  );

  fwd_pick #(.N_STG(N_STG), .AW(AW), .RDY_STG(RDY_STG), .FW(FW)) u_pick_rt (
    .stg_dest (bus.stg_dest_i),
    .stg_wr   (bus.stg_wr_i),
    .stg_load (bus.stg_load_i),
    .src      (bus.id_rt_i),
    .src_use  (bus.id_rt_use_i),
    .sel      (rt_sel),
    .load_nr  (rt_lnr)
  );

  // Load-use hazard, suppressed by a redirect; halt accepted only on a clean cycle
  always_comb begin
    hz_stall = bus.id_valid_i && (rs_lnr || rt_lnr) && !bus.redirect_i;
    halt_go  = bus.halt_req_i && bus.id_valid_i && !bus.redirect_i && !hz_stall;
  end

  // Run/drain/halted sequencing; drain counter loads N_STG and halts after reaching 0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      drain_cnt <= '0;
      halted    <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (halt_go) begin
            state     <= DRAIN;
            drain_cnt <= FW'(N_STG);
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        HALTED: state <= HALTED;
        default: begin
          state  <= RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

  // Outputs are combinational and forced quiet while reset is held
  always_comb begin
    bus.fwd_rs_o = rst_n ? rs_sel : '0;
    bus.fwd_rt_o = rst_n ? rt_sel : '0;
    bus.stall_o  = rst_n && ((state == RUN) ? hz_stall : 1'b1);
    bus.flush_o  = rst_n && (state == RUN) && bus.redirect_i;
    bus.halted_o = halted;
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_stall, perf_flush;

  // Saturating counters of hazard stalls in RUN and of flush cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall <= '0;
      perf_flush <= '0;
    end else begin
      if (bus.stall_o && (state == RUN) && (perf_stall != 32'hFFFF_FFFF))
        perf_stall <= perf_stall + 32'd1;
      if (bus.flush_o && (perf_flush != 32'hFFFF_FFFF))
        perf_flush <= perf_flush + 32'd1;
    end
  end

  assign bus.perf_stall_o = perf_stall;
  assign bus.perf_flush_o = perf_flush;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios plus random traffic
// checked against a behavioural model of the forwarding/stall/halt rules.
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  localparam int N_STG   = 3;
  localparam int AW      = 5;
  localparam int RDY_STG = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.N_STG(N_STG), .AW(AW)) if_h ();

  pipe_hazard_ctrl #(.N_STG(N_STG), .AW(AW), .RDY_STG(RDY_STG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_h.slave)
  );

  int checks = 0;
  int errors = 0;

  // stimulus state
  logic [AW-1:0]    dst [N_STG];
  logic [N_STG-1:0] wr, ld;
  logic             valid, rsu, rtu, redir, halt;
  logic [AW-1:0]    rs, rt;

  // model state: 0 run, 1 drain, 2 halted
  int     m_mode   = 0;
  int     m_drain  = 0;
  longint m_pstall = 0;
  longint m_pflush = 0;
  bit     e_stall, e_flush;
  int     e_rs, e_rt;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear();
    for (int i = 0; i < N_STG; i++) dst[i] = '0;
    wr = '0; ld = '0; valid = 1'b0; rsu = 1'b0; rtu = 1'b0;
    redir = 1'b0; halt = 1'b0; rs = '0; rt = '0;
  endtask

  task automatic apply();
    logic [N_STG*AW-1:0] pk;
    for (int i = 0; i < N_STG; i++) pk[i*AW +: AW] = dst[i];
    if_h.stg_dest_i  = pk;
    if_h.stg_wr_i    = wr;
    if_h.stg_load_i  = ld;
    if_h.id_valid_i  = valid;
    if_h.id_rs_i     = rs;
    if_h.id_rt_i     = rt;
    if_h.id_rs_use_i = rsu;
    if_h.id_rt_use_i = rtu;
    if_h.redirect_i  = redir;
    if_h.halt_req_i  = halt;
  endtask

  // Youngest producer of src, and whether it is a load not yet forwardable
  task automatic ref_src(input logic [AW-1:0] src, input logic use_,
                         output int sel, output bit lnr);
    sel = 0;
    lnr = 1'b0;
    if (use_ && src != 0) begin
      for (int i = 0; i < N_STG; i++) begin
        if (wr[i] && dst[i] == src) begin
          sel = i + 1;
          lnr = ld[i] && (i < RDY_STG);
          break;
        end
      end
    end
  endtask

  task automatic model_check();
    int srs, srt;
    bit lrs, lrt, hz;
    ref_src(rs, rsu, srs, lrs);
    ref_src(rt, rtu, srt, lrt);
    hz = valid && (lrs || lrt) && !redir;
    if (!rst_n) begin
      e_rs = 0; e_rt = 0; e_stall = 1'b0; e_flush = 1'b0;
    end else begin
      e_rs = srs; e_rt = srt;
      if (m_mode == 0) begin e_stall = hz;   e_flush = redir; end
      else             begin e_stall = 1'b1; e_flush = 1'b0;  end
    end
    chk("fwd_rs", if_h.fwd_rs_o, e_rs);
    chk("fwd_rt", if_h.fwd_rt_o, e_rt);
    chk("stall",  if_h.stall_o, e_stall);
    chk("flush",  if_h.flush_o, e_flush);
    chk("halted", if_h.halted_o, (m_mode == 2));
`ifdef PIPE_HAZARD_PERF_EN
    chk("perf_stall", if_h.perf_stall_o, m_pstall);
    chk("perf_flush", if_h.perf_flush_o, m_pflush);
`endif
  endtask

  task automatic model_update();
    if (!rst_n) begin
      m_mode = 0; m_drain = 0; m_pstall = 0; m_pflush = 0;
    end else begin
      if (m_mode == 0 && e_stall) m_pstall++;
      if (e_flush) m_pflush++;
      case (m_mode)
        0: if (halt && valid && !redir && !e_stall) begin m_mode = 1; m_drain = 0; end
        1: begin
          m_drain++;
          if (m_drain == N_STG + 1) m_mode = 2;
        end
        default: ;
      endcase
    end
  endtask

  // entered at posedge+1: outputs compared at the falling edge
  task automatic settle();
    apply();
    #4;
    model_check();
  endtask

  task automatic adv();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    clear();
    rst_n = 1'b0;
    valid = 1'b1; redir = 1'b1; wr = '1; ld = '1;
    dst[0] = 5'd3; rs = 5'd3; rsu = 1'b1;
    #1;
    settle();
    chk("rst_stall", if_h.stall_o, 0);
    chk("rst_flush", if_h.flush_o, 0);
    chk("rst_fwd",   if_h.fwd_rs_o, 0);
    adv();
    settle();
    adv();
    clear();
    rst_n = 1'b1;
    settle();
    chk("rst_halted", if_h.halted_o, 0);
    adv();

    // three load-use stalls, then two redirects
    for (int k = 0; k < 3; k++) begin
      clear();
      valid = 1'b1; dst[0] = 5'd9; wr[0] = 1'b1; ld[0] = 1'b1; rt = 5'd9; rtu = 1'b1;
      settle();
      chk("lu_stall", if_h.stall_o, 1);
      adv();
    end
    for (int k = 0; k < 2; k++) begin
      clear();
      valid = 1'b1; redir = 1'b1;
      settle();
      chk("redir_flush", if_h.flush_o, 1);
      adv();
    end
    clear();
    settle();
`ifdef PIPE_HAZARD_PERF_EN
    chk("perf3_stall", if_h.perf_stall_o, 3);
    chk("perf2_flush", if_h.perf_flush_o, 2);
`endif
    adv();

    // ALU result forwarded from EX
    clear();
    valid = 1'b1; dst[0] = 5'd8; wr[0] = 1'b1; rs = 5'd8; rsu = 1'b1;
    settle();
    chk("ex_fwd_rs", if_h.fwd_rs_o, 1);
    chk("ex_stall",  if_h.stall_o, 0);
    adv();

    // load-use: one bubble, then forward from stage 1
    clear();
    valid = 1'b1; dst[0] = 5'd9; wr[0] = 1'b1; ld[0] = 1'b1; rt = 5'd9; rtu = 1'b1;
    settle();
    chk("lu1_stall", if_h.stall_o, 1);
    adv();
    clear();
    valid = 1'b1; dst[1] = 5'd9; wr[1] = 1'b1; ld[1] = 1'b1; rt = 5'd9; rtu = 1'b1;
    settle();
    chk("lu2_fwd_rt", if_h.fwd_rt_o, 2);
    chk("lu2_stall",  if_h.stall_o, 0);
    adv();

    // youngest producer wins; register 0 never forwards
    clear();
    valid = 1'b1; dst[0] = 5'd5; dst[2] = 5'd5; wr = 3'b101; rs = 5'd5; rsu = 1'b1;
    settle();
    chk("young_fwd_rs", if_h.fwd_rs_o, 1);
    adv();
    clear();
    valid = 1'b1; wr = '1; ld = '1; rs = 5'd0; rsu = 1'b1; rt = 5'd0; rtu = 1'b1;
    settle();
    chk("r0_fwd_rs", if_h.fwd_rs_o, 0);
    chk("r0_stall",  if_h.stall_o, 0);
    adv();

    // redirect overrides load-use stall
    clear();
    valid = 1'b1; dst[0] = 5'd7; wr[0] = 1'b1; ld[0] = 1'b1; rs = 5'd7; rsu = 1'b1; redir = 1'b1;
    settle();
    chk("ov_flush", if_h.flush_o, 1);
    chk("ov_stall", if_h.stall_o, 0);
    adv();

    // halt: 4 drain cycles of stall then halted
    clear();
    valid = 1'b1; halt = 1'b1;
    settle();
    chk("halt_acc_stall", if_h.stall_o, 0);
    adv();
    for (int k = 0; k < N_STG + 1; k++) begin
      clear();
      valid = 1'b1; redir = (k == 1); halt = (k == 2);
      dst[2] = 5'd4; wr[2] = 1'b1; rs = 5'd4; rsu = 1'b1;
      settle();
      chk("drain_stall",  if_h.stall_o, 1);
      chk("drain_flush",  if_h.flush_o, 0);
      chk("drain_halted", if_h.halted_o, 0);
      chk("drain_fwd",    if_h.fwd_rs_o, 3);
      adv();
    end
    clear();
    settle();
    chk("halted_set",   if_h.halted_o, 1);
    chk("halted_stall", if_h.stall_o, 1);
    adv();
    rst_n = 1'b0;
    settle();
    adv();
    rst_n = 1'b1;

    // reset in the second drain cycle aborts the drain
    clear();
    valid = 1'b1; halt = 1'b1;
    settle();
    adv();
    clear();
    settle();
    chk("drain1_stall", if_h.stall_o, 1);
    adv();
    rst_n = 1'b0;
    settle();
    chk("abort_stall", if_h.stall_o, 0);
    adv();
    rst_n = 1'b1;
    settle();
    chk("abort_halted", if_h.halted_o, 0);
    chk("abort_run",    if_h.stall_o, 0);
    adv();

    // random traffic
    for (int n = 0; n < 800; n++) begin
      clear();
      rst_n = ($urandom_range(0, 39) != 0);
      valid = $urandom_range(0, 7) != 0;
      for (int i = 0; i < N_STG; i++) dst[i] = AW'($urandom_range(0, 3));
      wr    = N_STG'($urandom);
      ld    = N_STG'($urandom);
      rs    = AW'($urandom_range(0, 3));
      rt    = AW'($urandom_range(0, 3));
      rsu   = $urandom_range(0, 3) != 0;
      rtu   = $urandom_range(0, 3) != 0;
      redir = $urandom_range(0, 7) == 0;
      halt  = $urandom_range(0, 24) == 0;
      settle();
      adv();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter N_STG, default 3, meaning the number of in-flight stages after decode that may write the register file (index 0 = EX, youngest; N_STG-1 = WB, oldest).
REQ-002 SHALL have parameter AW, default 5, meaning the register-address width.
REQ-003 SHALL have parameter RDY_STG, default 1, meaning load data is forwardable only from stage index >= RDY_STG.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: synchronous active-low reset, sampled on the clk rising edge.
REQ-006 SHALL have port id_valid_i, input, 1 bit: the decode slot holds a real instruction.
REQ-007 SHALL have ports id_rs_i and id_rt_i, input, AW bits each: decode source registers.
REQ-008 SHALL have ports id_rs_use_i and id_rt_use_i, input, 1 bit each: the source is actually read.
REQ-009 SHALL have port stg_dest_i, input, N_STG*AW bits: the packed destination of each stage.
REQ-010 SHALL have ports stg_wr_i and stg_load_i, input, N_STG bits each: per-stage RegWrite and MemRead.
REQ-011 SHALL have port redirect_i, input, 1 bit: taken branch, jump or JR resolved this cycle.
REQ-012 SHALL have port halt_req_i, input, 1 bit: an all-zero instruction has been decoded.
REQ-013 SHALL have ports fwd_rs_o and fwd_rt_o, output, $clog2(N_STG+1) bits each: 0 = register file, k = stage k-1.
REQ-014 SHALL have port stall_o, output, 1 bit: hold PC and IF/ID, insert a bubble into ID/EX.
REQ-015 SHALL have port flush_o, output, 1 bit: clear IF/ID and ID/EX to bubbles.
REQ-016 SHALL have port halted_o, output, 1 bit: the pipeline is drained and stopped.

Function
REQ-017 SHALL match a source to stage i only when stg_wr_i[i]=1, dest==src, dest!=0 and use=1; register 0 never forwards or stalls.
REQ-018 SHALL select the lowest matching index (youngest producer) when several stages match; no match yields fwd=0.
REQ-019 SHALL compute fwd_*_o, stall_o and flush_o combinationally within the same cycle.
REQ-020 SHALL assert stall_o when id_valid_i=1 and a selected producer has stg_load_i=1 at index < RDY_STG (load-use hazard); with defaults this is exactly one bubble.
REQ-021 SHALL treat redirect_i as overriding a hazard stall: flush_o=1, stall_o=0 in that cycle.
REQ-022 SHALL implement the FSM RUN -> DRAIN on halt_req_i & id_valid_i & !redirect_i & !stall_o, so a halt decoded on the wrong path or while stalled is ignored.
REQ-023 SHALL, in DRAIN, hold stall_o=1, ignore redirect_i and halt_req_i, and count N_STG+1 cycles, then go to HALTED.
REQ-024 SHALL hold stall_o=1 and halted_o=1 in HALTED, which is left only by reset.
REQ-025 SHALL drive fwd_*_o from stage inputs normally in DRAIN, so older instructions still complete correctly.

Reset
REQ-026 SHALL, when rst_n=0 at a rising edge, force FSM=RUN, drain counter=0 and halted_o=0; reset during DRAIN or HALTED aborts it immediately.
REQ-027 SHALL hold flush_o=0, stall_o=0 and fwd=0 while rst_n is low, regardless of inputs.

Configuration
REQ-028 SHALL define macro PIPE_HAZARD_PERF_EN; when defined, it adds 32-bit outputs perf_stall_o and perf_flush_o counting cycles with stall_o=1 in RUN and cycles with flush_o=1, saturating at 0xFFFFFFFF and cleared by reset; when undefined, these ports and counters are absent and behaviour is otherwise identical.

Structure
REQ-029 SHALL place the FSM state enum (RUN, DRAIN, HALTED) and the fwd-select encoding constants in the shared package pipe_pkg.
REQ-030 SHALL use one sub-module, fwd_pick, which is instantiated twice (rs, rt) and returns the youngest-match index plus a load-not-ready flag.

Verification
REQ-031 SHALL test: stage0 dest=8, wr=1, load=0, id_rs=8 -> fwd_rs=1, stall=0.
REQ-032 SHALL test: stage0 dest=9 load=1, id_rt=9, rt_use=1 -> stall=1 for one cycle; next cycle, with the load in stage1, fwd_rt=2 and stall=0.
REQ-033 SHALL test: stages 0 and 2 both write reg 5, id_rs=5 -> fwd_rs=1; dest=0 in every stage with id_rs=0 -> fwd_rs=0.
REQ-034 SHALL test: load-use hazard and redirect_i in the same cycle -> flush_o=1, stall_o=0.
REQ-035 SHALL test: halt_req_i in RUN -> stall for 4 cycles, then halted_o=1; rst_n=0 on the 2nd DRAIN cycle -> RUN, halted_o=0.
REQ-036 SHALL test, with PIPE_HAZARD_PERF_EN: 3 load-use stalls and 2 redirects -> perf_stall_o=3, perf_flush_o=2.
